// File: rtl/multi_sync_filter.sv
// Multi-channel input conditioner: sync chain, glitch filter, edge strobes per channel.
// Optional saturating rising-edge counters are built when MSF_EDGE_CNT_EN is defined.
module multi_sync_filter #(
  parameter int unsigned N_CH   = 8,
  parameter int unsigned STAGES = 2,
  parameter int unsigned FILT   = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic [N_CH-1:0]         i_signal,
  input  logic                    i_cnt_clr,
  output logic [N_CH-1:0]         o_signal,
  output logic [N_CH-1:0]         o_rise,
  output logic [N_CH-1:0]         o_fall,
  output logic                    o_any_rise,
  output logic [N_CH*CNT_W-1:0]   o_count
);

  localparam int unsigned    RunW   = (FILT > 1) ? $clog2(FILT) : 1;
  localparam logic [RunW-1:0] RunMax = RunW'(FILT - 1);

  logic [N_CH-1:0] sync_q [STAGES];
  logic [N_CH-1:0] s;
  logic [RunW-1:0] run_q  [N_CH];
  logic [RunW-1:0] run_d  [N_CH];
  logic [N_CH-1:0] sig_q, sig_d;
  logic [N_CH-1:0] rise_q, rise_d;
  logic [N_CH-1:0] fall_q, fall_d;
  logic            any_rise_q;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= i_signal;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[STAGES-1];

  // A sample equal to the current output restarts the run, so only FILT
  // consecutive differing samples can flip the output.
  always_comb begin
    sig_d = sig_q;
    for (int k = 0; k < N_CH; k++) begin
      run_d[k] = run_q[k];
      if (s[k] == sig_q[k]) begin
        run_d[k] = '0;
      end else if (run_q[k] == RunMax) begin
        sig_d[k] = s[k];
        run_d[k] = '0;
      end else begin
        run_d[k] = run_q[k] + 1'b1;
      end
    end
    rise_d = sig_d & ~sig_q;
    fall_d = ~sig_d & sig_q;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int k = 0; k < N_CH; k++) run_q[k] <= '0;
      sig_q      <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      any_rise_q <= 1'b0;
    end else begin
      for (int k = 0; k < N_CH; k++) run_q[k] <= run_d[k];
      sig_q      <= sig_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      any_rise_q <= |rise_d;
    end
  end

  assign o_signal   = sig_q;
  assign o_rise     = rise_q;
  assign o_fall     = fall_q;
  assign o_any_rise = any_rise_q;

`ifdef MSF_EDGE_CNT_EN
  logic [CNT_W-1:0] cnt_q [N_CH];

  // A clear coinciding with a rise keeps that rise as the first count.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int k = 0; k < N_CH; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (i_cnt_clr) begin
          cnt_q[k] <= CNT_W'(rise_q[k]);
        end else if (rise_q[k] && (cnt_q[k] != '1)) begin
          cnt_q[k] <= cnt_q[k] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    o_count = '0;
    for (int k = 0; k < N_CH; k++) o_count[k*CNT_W +: CNT_W] = cnt_q[k];
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = i_cnt_clr;
  assign o_count        = '0;
`endif

endmodule

// File: tb/tb_multi_sync_filter.sv
// Directed bench for multi_sync_filter: per-cycle expectations queued ahead of each
// stimulus step and popped as the outputs are sampled 1 time unit after each edge.
module tb_multi_sync_filter;

  localparam int unsigned N_CH   = 8;
  localparam int unsigned STAGES = 2;
  localparam int unsigned FILT   = 3;
`ifdef MSF_EDGE_CNT_EN
  localparam int unsigned CNT_W  = 4;
`else
  localparam int unsigned CNT_W  = 16;
`endif

  logic                  clk = 1'b0;
  logic                  aresetn = 1'b0;
  logic [N_CH-1:0]       sig_in = '0;
  logic                  cnt_clr = 1'b0;
  logic [N_CH-1:0]       o_signal, o_rise, o_fall;
  logic                  o_any_rise;
  logic [N_CH*CNT_W-1:0] o_count;

  typedef struct {
    logic [N_CH-1:0] sig;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic            any;
  } exp_t;

  exp_t  exp_q[$];
  int    n_vec  = 0;
  int    n_fail = 0;
  string cur_tag = "init";

  multi_sync_filter #(
    .N_CH(N_CH), .STAGES(STAGES), .FILT(FILT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .aresetn(aresetn), .i_signal(sig_in), .i_cnt_clr(cnt_clr),
    .o_signal(o_signal), .o_rise(o_rise), .o_fall(o_fall),
    .o_any_rise(o_any_rise), .o_count(o_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [N_CH-1:0] sig, input logic [N_CH-1:0] rise,
                      input logic [N_CH-1:0] fall, input logic any);
    exp_t e;
    e.sig = sig; e.rise = rise; e.fall = fall; e.any = any;
    exp_q.push_back(e);
  endtask

  task automatic hold(input int n, input logic [N_CH-1:0] sig);
    for (int i = 0; i < n; i++) push(sig, '0, '0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".sig"},   256'(o_signal),   256'(0));
    check({tag, ".rise"},  256'(o_rise),     256'(0));
    check({tag, ".fall"},  256'(o_fall),     256'(0));
    check({tag, ".any"},   256'(o_any_rise), 256'(0));
    check({tag, ".count"}, 256'(o_count),    256'(0));
  endtask

  // Advance one edge per queued expectation and compare.
  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check({cur_tag, ".sig"},  256'(o_signal),   256'(e.sig));
      check({cur_tag, ".rise"}, 256'(o_rise),     256'(e.rise));
      check({cur_tag, ".fall"}, 256'(o_fall),     256'(e.fall));
      check({cur_tag, ".any"},  256'(o_any_rise), 256'(e.any));
`ifndef MSF_EDGE_CNT_EN
      check({cur_tag, ".count"}, 256'(o_count), 256'(0));
`endif
    end
  endtask

`ifdef MSF_EDGE_CNT_EN
  task automatic check_cnt(input string tag, input logic [CNT_W-1:0] ch2_exp);
    logic [N_CH*CNT_W-1:0] want;
    want = '0;
    want[2*CNT_W +: CNT_W] = ch2_exp;
    check(tag, 256'(o_count), 256'(want));
  endtask
`endif

  initial begin
    // Reset held with all inputs high.
    sig_in = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_hold");
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    cur_tag = "step_up";
    hold(4, 8'h00); push(8'hFF, 8'hFF, 8'h00, 1'b1); hold(2, 8'hFF);
    drain();

    cur_tag = "step_down";
    sig_in = 8'h00;
    hold(4, 8'hFF); push(8'h00, 8'h00, 8'hFF, 1'b0); hold(2, 8'h00);
    drain();

    cur_tag = "glitch2";
    sig_in = 8'h08; hold(2, 8'h00); drain();
    sig_in = 8'h00; hold(6, 8'h00); drain();

    cur_tag = "pulse3";
    sig_in = 8'h08; hold(3, 8'h00); drain();
    sig_in = 8'h00;
    hold(1, 8'h00); push(8'h08, 8'h08, 8'h00, 1'b1); hold(2, 8'h08);
    push(8'h00, 8'h00, 8'h08, 1'b0); hold(3, 8'h00);
    drain();

    cur_tag = "restart";
    sig_in = 8'h01; hold(2, 8'h00); drain();
    sig_in = 8'h00; hold(1, 8'h00); drain();
    sig_in = 8'h01; hold(3, 8'h00); drain();
    sig_in = 8'h00;
    hold(1, 8'h00); push(8'h01, 8'h01, 8'h00, 1'b1); hold(2, 8'h01);
    push(8'h00, 8'h00, 8'h01, 1'b0); hold(2, 8'h00);
    drain();

    cur_tag = "indep";
    sig_in = 8'h40;
    hold(4, 8'h00); push(8'h40, 8'h40, 8'h00, 1'b1); hold(1, 8'h40); drain();
    sig_in = 8'h02;
    hold(4, 8'h40); push(8'h02, 8'h02, 8'h40, 1'b1); hold(2, 8'h02); drain();
    sig_in = 8'h00;
    hold(4, 8'h02); push(8'h00, 8'h00, 8'h02, 1'b0); hold(1, 8'h00); drain();

`ifdef MSF_EDGE_CNT_EN
    cur_tag = "cnt";
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    check_cnt("cnt_clr_initial", '0);
    for (int i = 0; i < 20; i++) begin
      sig_in = 8'h04;
      hold(4, 8'h00); push(8'h04, 8'h04, 8'h00, 1'b1); drain();
      sig_in = 8'h00;
      hold(4, 8'h04); push(8'h00, 8'h00, 8'h04, 1'b0); drain();
      check_cnt("cnt_sat", (i + 1 > 15) ? CNT_W'(15) : CNT_W'(i + 1));
    end
    sig_in = 8'h04;
    hold(4, 8'h00); push(8'h04, 8'h04, 8'h00, 1'b1); drain();
    cnt_clr = 1'b1;
    hold(1, 8'h04); drain();
    cnt_clr = 1'b0;
    check_cnt("cnt_clr_with_rise", CNT_W'(1));
    cnt_clr = 1'b1;
    hold(1, 8'h04); drain();
    cnt_clr = 1'b0;
    check_cnt("cnt_clr_alone", '0);
    sig_in = 8'h00;
    hold(4, 8'h04); push(8'h00, 8'h00, 8'h04, 1'b0); drain();
`endif

    cur_tag = "midrst_pre";
    sig_in = 8'h20;
    hold(4, 8'h00); push(8'h20, 8'h20, 8'h00, 1'b1); hold(1, 8'h20); drain();
    sig_in = 8'h30;
    hold(3, 8'h20); drain();
    aresetn = 1'b0;
    #1;
    check_all_zero("midrst_async");
    @(posedge clk);
    #1;
    check_all_zero("midrst_held");
    aresetn = 1'b1;
    cur_tag = "midrst_post";
    hold(4, 8'h00); push(8'h30, 8'h30, 8'h00, 1'b1); hold(1, 8'h30); drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
